// File: rtl/if_id_buffer.sv
// IF/ID decoupling queue: circular FIFO of {instruction, pc+2} between
// fetch and decode, with backpressure on full and flush on a taken branch.
module if_id_buffer #(
    parameter int                DEPTH     = 2,
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            in_instruction,
    input  logic [ADDR_W-1:0]            in_next_address,
    input  logic                         in_valid,
    input  logic                         flush,
    output logic                         fetch_stall,
    output logic [DATA_W-1:0]            out_instruction,
    output logic [ADDR_W-1:0]            out_next_address,
    output logic                         out_valid,
    input  logic                         decode_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem  [DEPTH];
    logic              push;
    logic              pop;

    // Full is taken from the registered count only, so a same-cycle pop
    // never opens a slot for fetch: no combinational ready path.
    assign fetch_stall = (count == CNT_W'(DEPTH));
    assign out_valid   = (count != '0);
    assign occupancy   = count;

    assign push = in_valid & ~fetch_stall & ~flush;
    assign pop  = out_valid & decode_ready & ~flush;

    always_comb begin
        out_instruction  = NOP_INSTR;
        out_next_address = '0;
        if (out_valid) begin
            out_instruction  = instr_mem[rd_ptr];
            out_next_address = addr_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instruction;
            addr_mem[wr_ptr]  <= in_next_address;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: vector table plus hand-written
// sequences for reset, wrap-around and asynchronous reset.
module tb_if_id_buffer;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_instruction;
    logic [15:0] in_next_address;
    logic        in_valid;
    logic        flush;
    logic        fetch_stall;
    logic [15:0] out_instruction;
    logic [15:0] out_next_address;
    logic        out_valid;
    logic        decode_ready;
    logic [1:0]  occupancy;

    int total;
    int passed;

    if_id_buffer #(
        .DEPTH(2),
        .DATA_W(16),
        .ADDR_W(16),
        .NOP_INSTR(16'h0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_instruction(in_instruction),
        .in_next_address(in_next_address),
        .in_valid(in_valid),
        .flush(flush),
        .fetch_stall(fetch_stall),
        .out_instruction(out_instruction),
        .out_next_address(out_next_address),
        .out_valid(out_valid),
        .decode_ready(decode_ready),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        f;
        logic        r;
        logic [15:0] instr;
        logic [15:0] addr;
        logic        ov;
        logic [15:0] oi;
        logic [15:0] oa;
        logic        st;
        logic [1:0]  oc;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(logic v, logic f, logic r,
                                logic [15:0] instr, logic [15:0] addr,
                                logic ov, logic [15:0] oi,
                                logic [15:0] oa, logic st,
                                logic [1:0] oc);
        vec_t x;
        x.v = v; x.f = f; x.r = r;
        x.instr = instr; x.addr = addr;
        x.ov = ov; x.oi = oi; x.oa = oa;
        x.st = st; x.oc = oc;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic drive(logic v, logic f, logic r,
                         logic [15:0] instr, logic [15:0] addr);
        in_valid        = v;
        flush           = f;
        decode_ready    = r;
        in_instruction  = instr;
        in_next_address = addr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q[$];
        int          mcnt;
        int          k;
        logic        mpush;
        logic        mpop;

        total  = 0;
        passed = 0;

        // streaming
        vecs[0]  = mk(1,0,1,16'hA001,16'h0002, 1,16'hA001,16'h0002,0,2'd1);
        vecs[1]  = mk(1,0,1,16'hA002,16'h0004, 1,16'hA002,16'h0004,0,2'd1);
        vecs[2]  = mk(1,0,1,16'hA003,16'h0006, 1,16'hA003,16'h0006,0,2'd1);
        vecs[3]  = mk(0,0,1,16'h0000,16'h0000, 0,16'h0000,16'h0000,0,2'd0);
        // fill and backpressure
        vecs[4]  = mk(1,0,0,16'hA001,16'h0002, 1,16'hA001,16'h0002,0,2'd1);
        vecs[5]  = mk(1,0,0,16'hA002,16'h0004, 1,16'hA001,16'h0002,1,2'd2);
        vecs[6]  = mk(1,0,0,16'hA003,16'h0006, 1,16'hA001,16'h0002,1,2'd2);
        vecs[7]  = mk(1,0,1,16'hA003,16'h0006, 1,16'hA002,16'h0004,0,2'd1);
        vecs[8]  = mk(0,0,1,16'h0000,16'h0000, 0,16'h0000,16'h0000,0,2'd0);
        // flush with a full queue and a valid input
        vecs[9]  = mk(1,0,0,16'hC001,16'h00C2, 1,16'hC001,16'h00C2,0,2'd1);
        vecs[10] = mk(1,0,0,16'hC002,16'h00C4, 1,16'hC001,16'h00C2,1,2'd2);
        vecs[11] = mk(1,1,1,16'hC003,16'h00C6, 0,16'h0000,16'h0000,0,2'd0);
        vecs[12] = mk(1,0,0,16'hB000,16'h00B2, 1,16'hB000,16'h00B2,0,2'd1);
        vecs[13] = mk(0,0,1,16'h0000,16'h0000, 0,16'h0000,16'h0000,0,2'd0);
        // miss bubbles
        vecs[14] = mk(1,0,1,16'hD001,16'h00D2, 1,16'hD001,16'h00D2,0,2'd1);
        vecs[15] = mk(0,0,1,16'h0000,16'h0000, 0,16'h0000,16'h0000,0,2'd0);
        vecs[16] = mk(0,0,1,16'h0000,16'h0000, 0,16'h0000,16'h0000,0,2'd0);
        vecs[17] = mk(1,0,1,16'hD002,16'h00D4, 1,16'hD002,16'h00D4,0,2'd1);
        vecs[18] = mk(0,0,1,16'h0000,16'h0000, 0,16'h0000,16'h0000,0,2'd0);

        rst_n = 1'b0;
        drive(1, 0, 0, 16'h1234, 16'h5678);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", 32'(out_instruction), 32'h0000);
        chk("rst_out_addr", 32'(out_next_address), 32'h0000);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_fetch_stall", 32'(fetch_stall), 32'd0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            drive(vecs[i].v, vecs[i].f, vecs[i].r,
                  vecs[i].instr, vecs[i].addr);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i),
                32'(out_valid), 32'(vecs[i].ov));
            chk($sformatf("vec%0d_out_instr", i),
                32'(out_instruction), 32'(vecs[i].oi));
            chk($sformatf("vec%0d_out_addr", i),
                32'(out_next_address), 32'(vecs[i].oa));
            chk($sformatf("vec%0d_fetch_stall", i),
                32'(fetch_stall), 32'(vecs[i].st));
            chk($sformatf("vec%0d_occupancy", i),
                32'(occupancy), 32'(vecs[i].oc));
        end

        // wrap-around against a scoreboard, fetch holding when stalled
        mcnt = 0;
        k    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1, 0, (i % 2 == 0), 16'hE000 | 16'(k), 16'(2 * k));
            mpush = (mcnt != 2);
            mpop  = (mcnt != 0) && (i % 2 == 0);
            #1;
            if (mpop)
                chk($sformatf("wrap%0d_head", i),
                    32'(out_instruction), 32'(q[0]));
            @(posedge clk);
            if (mpop)
                void'(q.pop_front());
            if (mpush) begin
                q.push_back(16'hE000 | 16'(k));
                k++;
            end
            mcnt = q.size();
            #1;
            chk($sformatf("wrap%0d_occupancy", i),
                32'(occupancy), 32'(mcnt));
            chk($sformatf("wrap%0d_fetch_stall", i),
                32'(fetch_stall), 32'(mcnt == 2));
        end
        for (int i = 0; i < 2; i++) begin
            if (q.size() != 0) begin
                @(negedge clk);
                drive(0, 0, 1, 16'h0000, 16'h0000);
                #1;
                chk($sformatf("drain%0d_head", i),
                    32'(out_instruction), 32'(q[0]));
                chk($sformatf("drain%0d_addr", i),
                    32'(out_next_address), 32'((q[0] & 16'h0FFF) * 2));
                @(posedge clk);
                void'(q.pop_front());
            end
        end
        #1;
        chk("drain_empty", 32'(out_valid), 32'd0);

        // asynchronous reset mid-operation
        @(negedge clk);
        drive(1, 0, 0, 16'h7001, 16'h7002);
        @(negedge clk);
        drive(1, 0, 0, 16'h7003, 16'h7004);
        @(negedge clk);
        #1;
        chk("pre_arst_occupancy", 32'(occupancy), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_occupancy", 32'(occupancy), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_instr", 32'(out_instruction), 32'h0000);
        chk("arst_fetch_stall", 32'(fetch_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 16'hF001, 16'h00F2);
        #1;
        chk("post_arst_no_bypass", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("post_arst_instr", 32'(out_instruction), 32'hF001);
        chk("post_arst_addr", 32'(out_next_address), 32'h00F2);
        chk("post_arst_occupancy", 32'(occupancy), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
